// File: rtl/sge_window_peak.sv
// Signed windowed peak detector: tracks the latest signed maximum over each block of
// WINDOW valid samples and offers the peak and its in-window index on a valid/ready port.
module sge_window_peak #(
  parameter int WIDTH  = 8,
  parameter int WINDOW = 16,
  parameter int IDX_W  = (WINDOW > 1) ? $clog2(WINDOW) : 1
) (
  input  logic                    CLK,
  input  logic                    ASYNCRESET,
  input  logic                    I_valid,
  input  logic signed [WIDTH-1:0] I,
  input  logic                    CLR,
  output logic                    O_valid,
  input  logic                    O_ready,
  output logic signed [WIDTH-1:0] O,
  output logic [IDX_W-1:0]        O_idx,
  output logic                    O_overrun
);

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WINDOW - 1);

  logic [IDX_W-1:0]        cnt_q, cnt_d;
  logic signed [WIDTH-1:0] max_q, max_d;
  logic [IDX_W-1:0]        max_idx_q, max_idx_d;
  logic                    o_valid_q, o_valid_d;
  logic signed [WIDTH-1:0] o_q, o_d;
  logic [IDX_W-1:0]        o_idx_q, o_idx_d;
  logic                    overrun_q, overrun_d;

  logic                    take;
  logic                    complete;
  logic                    accept;
  logic                    replace;
  logic signed [WIDTH-1:0] peak;
  logic [IDX_W-1:0]        peak_idx;

  // Ties replace so the reported index is the latest occurrence of the peak.
  function automatic logic sge(input logic signed [WIDTH-1:0] a,
                               input logic signed [WIDTH-1:0] b);
    return a >= b;
  endfunction

  always_comb begin
    take     = I_valid && !CLR;
    complete = take && (cnt_q == LAST_IDX);
    accept   = o_valid_q && O_ready;
    // The first sample of a window loads unconditionally; cnt_q is then 0.
    replace  = (cnt_q == '0) || sge(I, max_q);
    peak     = replace ? I : max_q;
    peak_idx = replace ? cnt_q : max_idx_q;

    cnt_d     = cnt_q;
    max_d     = max_q;
    max_idx_d = max_idx_q;
    o_valid_d = o_valid_q;
    o_d       = o_q;
    o_idx_d   = o_idx_q;
    overrun_d = overrun_q;

    if (CLR) begin
      cnt_d     = '0;
      overrun_d = 1'b0;
    end else if (I_valid) begin
      max_d     = peak;
      max_idx_d = peak_idx;
      cnt_d     = complete ? '0 : cnt_q + IDX_W'(1);
    end

    if (accept) begin
      o_valid_d = 1'b0;
    end

    if (complete) begin
      o_d       = peak;
      o_idx_d   = peak_idx;
      o_valid_d = 1'b1;
      if (o_valid_q && !O_ready) begin
        overrun_d = 1'b1;
      end
    end
  end

  always_ff @(posedge CLK or posedge ASYNCRESET) begin
    if (ASYNCRESET) begin
      cnt_q     <= '0;
      max_q     <= '0;
      max_idx_q <= '0;
      o_valid_q <= 1'b0;
      o_q       <= '0;
      o_idx_q   <= '0;
      overrun_q <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      max_q     <= max_d;
      max_idx_q <= max_idx_d;
      o_valid_q <= o_valid_d;
      o_q       <= o_d;
      o_idx_q   <= o_idx_d;
      overrun_q <= overrun_d;
    end
  end

  assign O_valid   = o_valid_q;
  assign O         = o_q;
  assign O_idx     = o_idx_q;
  assign O_overrun = overrun_q;

endmodule

// File: tb/tb_sge_window_peak.sv
// Bench for sge_window_peak: a WINDOW=4 instance driven from a vector table and corner
// sequences, plus a WINDOW=1 instance; accepted results are scoreboarded against a queue.
module tb_sge_window_peak;

  logic clk = 1'b0;
  logic rst = 1'b0;

  logic              iv = 1'b0, clr = 1'b0, rdy = 1'b0;
  logic signed [7:0] din = '0;
  logic              ov, ovr;
  logic signed [7:0] o;
  logic [1:0]        oidx;

  logic              iv1 = 1'b0, rdy1 = 1'b0;
  logic signed [7:0] din1 = '0;
  logic              ov1, ovr1;
  logic signed [7:0] o1;
  logic [0:0]        oidx1;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    logic signed [7:0] o;
    logic [1:0]        idx;
  } exp_t;
  exp_t              q4[$];
  logic signed [7:0] q1[$];

  typedef struct {
    logic signed [7:0] s0, s1, s2, s3;
    logic signed [7:0] exp_o;
    logic [1:0]        exp_idx;
    bit                gaps;
  } vec_t;
  vec_t vt[7];

  sge_window_peak #(.WIDTH(8), .WINDOW(4)) dut (
    .CLK(clk), .ASYNCRESET(rst), .I_valid(iv), .I(din), .CLR(clr),
    .O_valid(ov), .O_ready(rdy), .O(o), .O_idx(oidx), .O_overrun(ovr)
  );

  sge_window_peak #(.WIDTH(8), .WINDOW(1)) dut1 (
    .CLK(clk), .ASYNCRESET(rst), .I_valid(iv1), .I(din1), .CLR(1'b0),
    .O_valid(ov1), .O_ready(rdy1), .O(o1), .O_idx(oidx1), .O_overrun(ovr1)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Scoreboard: a handshake seen before the edge means the consumer takes this result.
  always @(negedge clk) begin
    if (!rst && ov && rdy) begin
      if (q4.size() == 0) begin
        check("w4_unexpected_result", 1, 0);
      end else begin
        exp_t e;
        e = q4.pop_front();
        check("w4_peak", o, e.o);
        check("w4_idx", oidx, e.idx);
      end
    end
    if (!rst && ov1 && rdy1) begin
      if (q1.size() == 0) begin
        check("w1_unexpected_result", 1, 0);
      end else begin
        logic signed [7:0] e1;
        e1 = q1.pop_front();
        check("w1_peak", o1, e1);
        check("w1_idx", oidx1, 0);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic signed [7:0] s);
    iv  = 1'b1;
    din = s;
    tick();
    iv  = 1'b0;
  endtask

  task automatic send1(input logic signed [7:0] s);
    iv1  = 1'b1;
    din1 = s;
    tick();
    iv1  = 1'b0;
  endtask

  initial begin
    logic signed [7:0] smp[4];
    exp_t e;

    vt[0] = '{s0:  3, s1:   -5, s2:    7, s3:    7, exp_o:   7, exp_idx: 3, gaps: 0};
    vt[1] = '{s0: -128, s1:  -1, s2:   -2, s3: -128, exp_o:  -1, exp_idx: 1, gaps: 0};
    vt[2] = '{s0:  1, s1:    2, s2:    3, s3:    4, exp_o:   4, exp_idx: 3, gaps: 1};
    vt[3] = '{s0: 127, s1: -128, s2:  127, s3:    0, exp_o: 127, exp_idx: 2, gaps: 0};
    vt[4] = '{s0: -3, s1:   -3, s2:   -3, s3:   -3, exp_o:  -3, exp_idx: 3, gaps: 1};
    vt[5] = '{s0: -5, s1:   -6, s2:   -7, s3:   -8, exp_o:  -5, exp_idx: 0, gaps: 0};
    vt[6] = '{s0:  5, s1:  127, s2: -128, s3:  126, exp_o: 127, exp_idx: 1, gaps: 0};

    // Reset state
    #1 rst = 1'b1;
    #3;
    check("rst_o_valid", ov, 0);
    check("rst_o", o, 0);
    check("rst_o_idx", oidx, 0);
    check("rst_overrun", ovr, 0);
    check("rst_w1_o_valid", ov1, 0);
    tick();
    rst = 1'b0;
    tick();

    // Table: back-to-back windows, some with idle gaps between samples
    rdy = 1'b1;
    for (int k = 0; k < 7; k++) begin
      smp[0] = vt[k].s0; smp[1] = vt[k].s1; smp[2] = vt[k].s2; smp[3] = vt[k].s3;
      e.o = vt[k].exp_o; e.idx = vt[k].exp_idx;
      q4.push_back(e);
      for (int j = 0; j < 4; j++) begin
        send(smp[j]);
        if (vt[k].gaps && j < 3) begin
          tick();
          tick();
        end
      end
      check("valid_after_last_sample", ov, 1);
    end
    tick();
    check("valid_drops_after_accept", ov, 0);
    check("no_overrun_when_ready", ovr, 0);

    // Overrun: two windows unaccepted, CLR clears the sticky flag only
    rdy = 1'b0;
    send(1); send(2); send(3); send(4);
    check("ovr_first_o", o, 4);
    check("ovr_first_flag", ovr, 0);
    send(9); send(8); send(7); send(6);
    check("ovr_second_o", o, 9);
    check("ovr_second_idx", oidx, 0);
    check("ovr_flag_set", ovr, 1);
    tick(); tick();
    check("ovr_hold_valid", ov, 1);
    check("ovr_hold_o", o, 9);
    clr = 1'b1;
    tick();
    clr = 1'b0;
    check("clr_clears_ovr", ovr, 0);
    check("clr_keeps_valid", ov, 1);
    check("clr_keeps_o", o, 9);
    e.o = 9; e.idx = 0;
    q4.push_back(e);
    rdy = 1'b1;
    tick();
    check("ovr_accepted_valid_low", ov, 0);

    // CLR with a valid sample discards it and the partial window
    send(5); send(9);
    clr = 1'b1; iv = 1'b1; din = 100;
    tick();
    clr = 1'b0; iv = 1'b0;
    e.o = 4; e.idx = 3;
    q4.push_back(e);
    send(1); send(2); send(3); send(4);
    check("clr_window_valid", ov, 1);
    tick();

    // Asynchronous reset mid-window with a pending result
    rdy = 1'b0;
    send(1); send(2); send(3); send(50);
    check("pre_reset_o", o, 50);
    send(10); send(20);
    #1 rst = 1'b1;
    #1;
    check("async_rst_valid", ov, 0);
    check("async_rst_o", o, 0);
    check("async_rst_idx", oidx, 0);
    check("async_rst_ovr", ovr, 0);
    rst = 1'b0;
    rdy = 1'b1;
    e.o = 40; e.idx = 3;
    q4.push_back(e);
    send(10); send(20); send(30); send(40);
    check("post_rst_o", o, 40);
    check("post_rst_idx", oidx, 3);
    tick();

    // WINDOW=1: every sample is a result; back-to-back accept+complete on one edge
    rdy1 = 1'b1;
    q1.push_back(127);
    send1(127);
    check("w1_first_valid", ov1, 1);
    tick(); tick();
    q1.push_back(-128);
    send1(-128);
    tick();
    q1.push_back(3);
    q1.push_back(4);
    q1.push_back(-1);
    send1(3); send1(4); send1(-1);
    check("w1_backtoback_o", o1, -1);
    tick();
    check("w1_no_overrun", ovr1, 0);

    // Drain: every expected result must have been accepted
    for (int c = 0; c < 20 && (q4.size() != 0 || q1.size() != 0); c++) begin
      tick();
    end
    check("w4_queue_drained", q4.size(), 0);
    check("w1_queue_drained", q1.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

endmodule
